pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RV32 pipeline with RVC support.
- Combines instruction-cache and data-cache stalls, load-use hazard detection (ID against EX), and branch-misprediction recovery (resolved in EX).
- Drives per-stage hold, bubble and flush controls and a registered PC redirect to IF.
- Keeps saturating performance counters for branches, mispredicts and stall cycles.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned MEM_W     = 2;
  localparam int unsigned MEM_READ  = 1;
  localparam int unsigned MEM_WRITE = 0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  typedef struct packed {
    logic hold_if;
    logic flush_if_id;
    logic bubble_id_ex;
    logic redirect_valid;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NOP = '0;

  // Load in EX whose rd feeds a source register of the ID instruction; x0 never hazards.
  function automatic logic load_use(
    input logic [MEM_W-1:0] mem_ex,
    input logic [REG_W-1:0] rd_ex,
    input logic [REG_W-1:0] rs1_id,
    input logic [REG_W-1:0] rs2_id,
    input logic             use_rs2_id
  );
    return mem_ex[MEM_READ] && (rd_ex != '0) &&
           ((rd_ex == rs1_id) || (use_rs2_id && (rd_ex == rs2_id)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module pipeline_hazard_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: merges cache stalls, load-use bubbles and mispredict
// recovery into per-stage controls, a registered PC redirect and perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned     CNT_W    = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic [REG_W-1:0] Rs1_1,
  input  logic [REG_W-1:0] Rs2_1,
  input  logic             use_rs2_1,
  input  logic [MEM_W-1:0] Mem_2,
  input  logic [REG_W-1:0] Rd_2,
  input  logic             is_branchInst_3,
  input  logic             taken_3,
  input  logic             prev_taken_3,
  input  logic [XLEN-1:0]  target_3,
  input  logic             perf_clr,
  output logic             memory_stall,
  output logic             hold_if,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] misp_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e   state, state_nxt;
  hz_ctrl_t ctrl;
  logic     redirect_load;
  logic     misp;
  logic     lu;
  logic     unused_mem_write;

  assign unused_mem_write = Mem_2[MEM_WRITE];

  assign memory_stall = icache_stall | dcache_stall;
  assign misp         = is_branchInst_3 & (taken_3 ^ prev_taken_3);
  assign lu           = load_use(Mem_2, Rd_2, Rs1_1, Rs2_1, use_rs2_1);

  // State register and redirect target latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      redirect_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_load) begin
        redirect_pc <= target_3;
      end
    end
  end

  // Next state and stage controls; a memory stall freezes everything.
  always_comb begin
    state_nxt     = state;
    ctrl          = CTRL_NOP;
    redirect_load = 1'b0;
    if (memory_stall) begin
      ctrl.hold_if = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (misp) begin
            ctrl.bubble_id_ex = 1'b1;
            ctrl.flush_if_id  = 1'b1;
            redirect_load     = 1'b1;
            state_nxt         = ST_REDIRECT;
          end else if (lu) begin
            ctrl.hold_if      = 1'b1;
            ctrl.bubble_id_ex = 1'b1;
          end
        end
        ST_REDIRECT: begin
          ctrl.redirect_valid = 1'b1;
          ctrl.flush_if_id    = 1'b1;
          state_nxt           = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign hold_if        = ctrl.hold_if;
  assign flush_if_id    = ctrl.flush_if_id;
  assign bubble_id_ex   = ctrl.bubble_id_ex;
  assign redirect_valid = ctrl.redirect_valid;

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_branchInst_3 & ~memory_stall),
    .clr   (perf_clr),
    .cnt   (branch_cnt)
  );

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_misp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (misp & ~memory_stall & (state == ST_RUN)),
    .clr   (perf_clr),
    .cnt   (misp_cnt)
  );

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (memory_stall),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

endmodule
